// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared definitions for the branch predictor slice:
//   - 4-bit branch class codes carried on the resolve interface
//   - helpers that classify a class code as conditional / unconditional
//   - counter reset / allocate / saturate constants, built from the counter
//     width (1..8 bits)
// No ports (package).
// ---------------------------------------------------------------------------
package br_pkg;

    typedef enum logic [3:0] {
        CB_NONE = 4'd0,
        CB_J    = 4'd1,
        CB_BEQ  = 4'd2,
        CB_BNE  = 4'd3,
        CB_BLEZ = 4'd4,
        CB_BGTZ = 4'd5,
        CB_BLTZ = 4'd6,
        CB_BGEZ = 4'd7,
        CB_JAL  = 4'd8,
        CB_JR   = 4'd9
    } br_class_e;

    localparam int CNT_W_MAX = 8;

    function automatic logic isCond(input logic [3:0] cb);
        return (cb inside {CB_BEQ, CB_BNE, CB_BLEZ, CB_BGTZ, CB_BLTZ, CB_BGEZ});
    endfunction

    function automatic logic isUncond(input logic [3:0] cb);
        return (cb inside {CB_J, CB_JAL, CB_JR});
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set (2-bit: 01).
    function automatic logic [CNT_W_MAX-1:0] cntWeakNotTaken(input int w);
        return (8'd1 << (w - 1)) - 8'd1;
    endfunction

    // Weakly-taken: MSB set, all lower bits clear (2-bit: 10).
    function automatic logic [CNT_W_MAX-1:0] cntWeakTaken(input int w);
        return 8'd1 << (w - 1);
    endfunction

    // Saturation ceiling: all w bits set.
    function automatic logic [CNT_W_MAX-1:0] cntMax(input int w);
        return 8'hFF >> (CNT_W_MAX - w);
    endfunction

endpackage

// File: rtl/br_ras.sv
// ---------------------------------------------------------------------------
// br_ras
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. Only instantiated when the predictor
// is built with BR_RAS_EN defined.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (clears pointer and count)
//   i_push       push i_pushData this cycle
//   i_pushData   return address to push
//   i_pop        pop the top entry this cycle
//   o_top        current top-of-stack value
//   o_empty      stack holds no entries
// ---------------------------------------------------------------------------
module br_ras #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [31:0] i_pushData,
    input  logic        i_pop,
    output logic [31:0] o_top,
    output logic        o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_stack [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_topIdx;
    logic [PTR_W-1:0] w_nextPtr;

    // r_ptr names the next free slot, so the top lives one slot below it,
    // wrapping circularly.
    assign w_topIdx  = (r_ptr == '0) ? PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
    assign w_nextPtr = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign o_top     = r_stack[w_topIdx];
    assign o_empty   = (r_count == '0);

    // Storage carries no reset; entries are only read once the count says
    // they were written.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_push) begin
            r_stack[r_ptr] <= i_pushData;
        end
    end

    // Pointer and occupancy; the count saturates at DEPTH so that a push
    // onto a full stack quietly replaces the oldest entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= w_nextPtr;
            if (r_count != CNT_W'(DEPTH)) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && (r_count != '0)) begin
            r_ptr   <= w_topIdx;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/br_predictor.sv
// ---------------------------------------------------------------------------
// br_predictor
// Direct-mapped BTB with a per-entry saturating direction counter.
// Lookup is purely combinational on i_if_pc; resolved branches update the
// table on the rising edge and produce a registered mispredict/redirect.
// Optional feature macro: BR_RAS_EN adds a return-address stack (br_ras);
// jal pushes pc+8, jr pops, and a jr hit predicts the stack top.
// Ports:
//   i_clk, i_rst                clock and synchronous active-high reset
//   i_if_pc                     fetch PC to predict
//   o_pred_hit/_taken/_target   combinational prediction for i_if_pc
//   i_upd_valid                 resolved control instruction present
//   i_upd_pc/_cb/_taken/_target resolved PC, class, direction and target
//   i_upd_pred_taken/_target    prediction originally made for i_upd_pc
//   o_mispredict, o_redirect_pc registered flush pulse and correct fetch PC
//   o_miss_cnt                  saturating misprediction count
// ---------------------------------------------------------------------------
module br_predictor
    import br_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic [3:0]  i_upd_cb,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CNT_W_MAX-1:0] CNT_RST_B   = cntWeakNotTaken(CNT_W);
    localparam logic [CNT_W_MAX-1:0] CNT_ALLOC_B = cntWeakTaken(CNT_W);
    localparam logic [CNT_W_MAX-1:0] CNT_MAX_B   = cntMax(CNT_W);
    localparam logic [CNT_W-1:0]     CNT_RST     = CNT_RST_B[CNT_W-1:0];
    localparam logic [CNT_W-1:0]     CNT_ALLOC   = CNT_ALLOC_B[CNT_W-1:0];
    localparam logic [CNT_W-1:0]     CNT_MAX     = CNT_MAX_B[CNT_W-1:0];

    if (ENTRIES < 4 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0 ||
        CNT_W < 1 || CNT_W > CNT_W_MAX || RAS_DEPTH < 2) begin : g_badParam
        $error("br_predictor: illegal parameter value");
    end

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic             r_uncond [ENTRIES];
    logic             r_mispredict;
    logic [31:0]      r_redirectPc;
    logic [31:0]      r_missCnt;

    logic [IDX_W-1:0] w_lkIdx, w_updIdx;
    logic [TAG_W-1:0] w_lkTag, w_updTag;
    logic             w_lkHit, w_lkTaken;
    logic             w_updHit, w_updCond, w_updUncond, w_updFire, w_updMisp;
    logic [CNT_W-1:0] w_cntCur, w_cntInc, w_cntDec;

    assign w_lkIdx  = i_if_pc[IDX_W+1:2];
    assign w_lkTag  = i_if_pc[31:IDX_W+2];
    assign w_updIdx = i_upd_pc[IDX_W+1:2];
    assign w_updTag = i_upd_pc[31:IDX_W+2];

`ifdef BR_RAS_EN
    logic        r_isJr [ENTRIES];
    logic [31:0] w_rasTop;
    logic        w_rasEmpty;

    br_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_updFire && (i_upd_cb == CB_JAL)),
        .i_pushData (i_upd_pc + 32'd8),
        .i_pop      (w_updFire && (i_upd_cb == CB_JR)),
        .o_top      (w_rasTop),
        .o_empty    (w_rasEmpty)
    );
`endif

    // Lookup sees only the pre-edge table; an update landing on the same
    // index this cycle is deliberately not forwarded.
    assign w_lkHit   = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
    assign w_lkTaken = w_lkHit && (r_uncond[w_lkIdx] || r_cnt[w_lkIdx][CNT_W-1]);

    always_comb begin
        o_pred_target = i_if_pc + 32'd8;
        if (w_lkTaken) begin
            o_pred_target = r_target[w_lkIdx];
`ifdef BR_RAS_EN
            if (r_isJr[w_lkIdx] && !w_rasEmpty) begin
                o_pred_target = w_rasTop;
            end
`endif
        end
    end

    assign o_pred_hit   = w_lkHit;
    assign o_pred_taken = w_lkTaken;

    // Unknown class codes are treated like class none: no table change and
    // no mispredict.
    assign w_updCond   = isCond(i_upd_cb);
    assign w_updUncond = isUncond(i_upd_cb);
    assign w_updFire   = i_upd_valid && (w_updCond || w_updUncond);
    assign w_updHit    = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_updMisp   = w_updFire && ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_target != i_upd_pred_target)));

    assign w_cntCur = r_cnt[w_updIdx];
    assign w_cntInc = (w_cntCur == CNT_MAX) ? w_cntCur : w_cntCur + 1'b1;
    assign w_cntDec = (w_cntCur == '0)      ? w_cntCur : w_cntCur - 1'b1;

    // Table update. Unconditional classes always (re)allocate as strongly
    // taken; conditional hits train the counter; a conditional miss only
    // allocates when taken, so never-taken branches do not pollute the BTB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_RST;
            end
        end else if (w_updFire) begin
            if (w_updUncond) begin
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= i_upd_target;
                r_cnt[w_updIdx]    <= CNT_MAX;
                r_uncond[w_updIdx] <= 1'b1;
`ifdef BR_RAS_EN
                r_isJr[w_updIdx]   <= (i_upd_cb == CB_JR);
`endif
            end else if (w_updHit) begin
                r_cnt[w_updIdx]    <= i_upd_taken ? w_cntInc : w_cntDec;
                r_uncond[w_updIdx] <= 1'b0;
                if (i_upd_taken) begin
                    r_tag[w_updIdx]    <= w_updTag;
                    r_target[w_updIdx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= i_upd_target;
                r_cnt[w_updIdx]    <= CNT_ALLOC;
                r_uncond[w_updIdx] <= 1'b0;
`ifdef BR_RAS_EN
                r_isJr[w_updIdx]   <= 1'b0;
`endif
            end
        end
    end

    // Registered flush request: the pulse follows the offending update by
    // one cycle, and the redirect PC holds until the next real update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mispredict <= 1'b0;
            r_redirectPc <= '0;
            r_missCnt    <= '0;
        end else begin
            r_mispredict <= w_updMisp;
            if (w_updFire) begin
                r_redirectPc <= i_upd_taken ? i_upd_target : i_upd_pc + 32'd8;
            end
            if (w_updMisp && (r_missCnt != 32'hFFFF_FFFF)) begin
                r_missCnt <= r_missCnt + 32'd1;
            end
        end
    end

    assign o_mispredict  = r_mispredict;
    assign o_redirect_pc = r_redirectPc;
    assign o_miss_cnt    = r_missCnt;

endmodule

// File: tb/tb_br_predictor.sv
// ---------------------------------------------------------------------------
// tb_br_predictor
// Directed stimulus for br_predictor. Each driven vector pushes its
// hand-computed expectation into a queue; an independent monitor pops and
// compares when a lookup or a resolved update is presented.
// ---------------------------------------------------------------------------
module tb_br_predictor;
    import br_pkg::*;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0050;
    localparam logic [31:0] PC_C = 32'h0040_0024;
    localparam logic [31:0] PC_D = 32'h0040_0030;
    localparam logic [31:0] PC_E = 32'h0040_0034;
    localparam logic [31:0] PC_F = 32'h0040_0038;
    localparam logic [31:0] PC_G = 32'h0040_0204;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifPc = '0;
    logic        predHit, predTaken;
    logic [31:0] predTarget;
    logic        updValid = 1'b0;
    logic [31:0] updPc = '0;
    logic [3:0]  updCb = '0;
    logic        updTaken = 1'b0;
    logic [31:0] updTarget = '0;
    logic        updPredTaken = 1'b0;
    logic [31:0] updPredTarget = '0;
    logic        mispredict;
    logic [31:0] redirectPc, missCnt;

    typedef struct {
        logic        misp;
        logic [31:0] redir;
        logic [31:0] cnt;
        string       name;
    } updExp_t;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        string       name;
    } lkExp_t;

    updExp_t     updQ[$];
    lkExp_t      lkQ[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] expRedir = '0;
    logic [31:0] expCnt = '0;
    bit          lkActive = 1'b0;

    always #5 clk = ~clk;

    br_predictor #(.ENTRIES(16), .CNT_W(2), .RAS_DEPTH(4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_if_pc           (ifPc),
        .o_pred_hit        (predHit),
        .o_pred_taken      (predTaken),
        .o_pred_target     (predTarget),
        .i_upd_valid       (updValid),
        .i_upd_pc          (updPc),
        .i_upd_cb          (updCb),
        .i_upd_taken       (updTaken),
        .i_upd_target      (updTarget),
        .i_upd_pred_taken  (updPredTaken),
        .i_upd_pred_target (updPredTarget),
        .o_mispredict      (mispredict),
        .o_redirect_pc     (redirectPc),
        .o_miss_cnt        (missCnt)
    );

    // One comparison; failures are reported and counted.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Drive a resolved update and queue its expected registered response.
    task automatic queueUpd(input logic [31:0] pc, input logic [3:0] cb,
                            input logic tk, input logic [31:0] tgt,
                            input logic pTk, input logic [31:0] pTgt,
                            input logic expMisp, input string name);
        updExp_t e;
        updValid = 1'b1;
        updPc = pc;
        updCb = cb;
        updTaken = tk;
        updTarget = tgt;
        updPredTaken = pTk;
        updPredTarget = pTgt;
        if (cb != CB_NONE) expRedir = tk ? tgt : pc + 32'd8;
        if (expMisp) expCnt = expCnt + 32'd1;
        e.misp = expMisp;
        e.redir = expRedir;
        e.cnt = expCnt;
        e.name = name;
        updQ.push_back(e);
    endtask

    // Drive a lookup PC and queue the expected combinational prediction.
    task automatic queueLook(input logic [31:0] pc, input logic hit,
                             input logic tk, input logic [31:0] tgt,
                             input string name);
        lkExp_t e;
        ifPc = pc;
        lkActive = 1'b1;
        e.hit = hit;
        e.taken = tk;
        e.target = tgt;
        e.name = name;
        lkQ.push_back(e);
    endtask

    // Advance one cycle and retire whatever was driven.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        updValid = 1'b0;
        lkActive = 1'b0;
    endtask

    // Monitor: sample at the rising edge whether an update was accepted,
    // compare its registered response and any active lookup at the falling
    // edge. With no update, mispredict must be quiet.
    initial begin
        bit fired;
        updExp_t u;
        lkExp_t l;
        forever begin
            @(posedge clk);
            fired = updValid && !rst;
            @(negedge clk);
            if (fired) begin
                if (updQ.size() == 0) begin
                    checkOutput("updQueueUnderflow", 32'd1, 32'd0);
                end else begin
                    u = updQ.pop_front();
                    checkOutput({u.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, u.misp});
                    checkOutput({u.name, ".redirect"}, redirectPc, u.redir);
                    checkOutput({u.name, ".missCnt"}, missCnt, u.cnt);
                end
            end else begin
                checkOutput("idleMispredict", {31'd0, mispredict}, 32'd0);
            end
            if (lkActive) begin
                if (lkQ.size() == 0) begin
                    checkOutput("lkQueueUnderflow", 32'd1, 32'd0);
                end else begin
                    l = lkQ.pop_front();
                    checkOutput({l.name, ".hit"}, {31'd0, predHit}, {31'd0, l.hit});
                    checkOutput({l.name, ".taken"}, {31'd0, predTaken}, {31'd0, l.taken});
                    checkOutput({l.name, ".target"}, predTarget, l.target);
                end
            end
        end
    end

    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        // Reset with a taken update held on the port; it must be discarded.
        rst = 1'b1;
        updValid = 1'b1;
        updPc = PC_C;
        updCb = CB_BEQ;
        updTaken = 1'b1;
        updTarget = 32'h0040_0444;
        updPredTaken = 1'b0;
        updPredTarget = PC_C + 32'd8;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstRedirect", redirectPc, 32'd0);
        checkOutput("rstMissCnt", missCnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        updValid = 1'b0;

        queueLook(PC_A, 0, 0, 32'h0040_0018, "coldLookupA");
        applyStimulus();
        queueLook(PC_C, 0, 0, 32'h0040_002C, "rstUpdNoAlloc");
        applyStimulus();

        // First taken beq allocates weakly-taken; same-cycle lookup is old.
        queueUpd(PC_A, CB_BEQ, 1, 32'h0040_0000, 0, 32'h0040_0018, 1, "allocA");
        queueLook(PC_A, 0, 0, 32'h0040_0018, "sameCycleOld");
        applyStimulus();
        queueLook(PC_A, 1, 1, 32'h0040_0000, "hitA");
        applyStimulus();

        // Counter 2 -> 1 -> 0 -> 0 on three not-taken, back-to-back.
        queueUpd(PC_A, CB_BEQ, 0, 32'h0040_0000, 1, 32'h0040_0000, 1, "ntA1");
        applyStimulus();
        queueLook(PC_A, 1, 0, 32'h0040_0018, "afterNt1");
        applyStimulus();
        queueUpd(PC_A, CB_BEQ, 0, 32'h0040_0000, 0, 32'h0040_0018, 0, "ntA2");
        applyStimulus();
        queueUpd(PC_A, CB_BEQ, 0, 32'h0040_0000, 0, 32'h0040_0018, 0, "ntA3");
        applyStimulus();

        // From 0, one taken gives 1 (still not-taken), a second gives 2.
        queueUpd(PC_A, CB_BEQ, 1, 32'h0040_0000, 0, 32'h0040_0018, 1, "tkA1");
        queueLook(PC_A, 1, 0, 32'h0040_0018, "sameCycleCnt0");
        applyStimulus();
        queueLook(PC_A, 1, 0, 32'h0040_0018, "floorHeld");
        applyStimulus();
        queueUpd(PC_A, CB_BEQ, 1, 32'h0040_0000, 0, 32'h0040_0018, 1, "tkA2");
        applyStimulus();
        queueLook(PC_A, 1, 1, 32'h0040_0000, "retrained");
        applyStimulus();

        // Right direction, wrong target: still a mispredict, target rewritten.
        queueUpd(PC_A, CB_BEQ, 1, 32'h0040_0040, 1, 32'h0040_0000, 1, "newTgtA");
        applyStimulus();
        queueLook(PC_A, 1, 1, 32'h0040_0040, "hitNewTgt");
        applyStimulus();

        // Same index, different tag: B evicts A.
        queueUpd(PC_B, CB_BNE, 1, 32'h0040_0080, 0, 32'h0040_0058, 1, "allocB");
        applyStimulus();
        queueLook(PC_A, 0, 0, 32'h0040_0018, "evictedA");
        applyStimulus();
        queueLook(PC_B, 1, 1, 32'h0040_0080, "hitB");
        applyStimulus();

        // Not-taken conditional miss must not allocate.
        queueUpd(PC_D, CB_BEQ, 0, 32'h0040_0700, 0, 32'h0040_0038, 0, "ntMissD");
        applyStimulus();
        queueLook(PC_D, 0, 0, 32'h0040_0038, "noAllocD");
        applyStimulus();

        // Unconditional j allocates strongly taken.
        queueUpd(PC_E, CB_J, 1, 32'h0040_0400, 0, 32'h0040_003C, 1, "jE");
        applyStimulus();
        queueLook(PC_E, 1, 1, 32'h0040_0400, "hitJ");
        applyStimulus();

        // Class none: no table change, no mispredict, redirect held.
        queueUpd(PC_F, CB_NONE, 1, 32'h0040_0500, 0, 32'h0040_0040, 0, "noneF");
        applyStimulus();
        queueLook(PC_F, 0, 0, 32'h0040_0040, "noneNoAlloc");
        applyStimulus();

        // Correctly predicted j: no mispredict.
        queueUpd(PC_E, CB_J, 1, 32'h0040_0400, 1, 32'h0040_0400, 0, "jECorrect");
        applyStimulus();

        // jr predicted from the stored target (RAS empty or absent).
        queueUpd(PC_G, CB_JR, 1, 32'h0040_0300, 0, 32'h0040_020C, 1, "jrG");
        applyStimulus();
        queueLook(PC_G, 1, 1, 32'h0040_0300, "jrStored");
        applyStimulus();

`ifdef BR_RAS_EN
        begin
            logic [31:0] lifo [4];
            lifo[0] = 32'h0040_0148;
            lifo[1] = 32'h0040_0138;
            lifo[2] = 32'h0040_0128;
            lifo[3] = 32'h0040_0118;
            queueUpd(32'h0040_0100, CB_JAL, 1, 32'h0040_0600, 1, 32'h0040_0600, 0, "jal0");
            applyStimulus();
            queueLook(PC_G, 1, 1, 32'h0040_0108, "rasTop");
            applyStimulus();
            for (int i = 1; i < 5; i++) begin
                queueUpd(32'h0040_0100 + 32'(16 * i), CB_JAL, 1, 32'h0040_0600,
                         1, 32'h0040_0600, 0, "jalPush");
                applyStimulus();
            end
            for (int i = 0; i < 4; i++) begin
                queueUpd(PC_G, CB_JR, 1, 32'h0040_0300, 1, 32'h0040_0300, 0, "jrPop");
                queueLook(PC_G, 1, 1, lifo[i], "rasLifo");
                applyStimulus();
            end
            queueLook(PC_G, 1, 1, 32'h0040_0300, "rasEmptyFallback");
            applyStimulus();
        end
`endif

        applyStimulus();
        applyStimulus();
        checkOutput("updQueueDrained", 32'(updQ.size()), 32'd0);
        checkOutput("lkQueueDrained", 32'(lkQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
